uart_str_tx: RTL and testbench
==============================

// Module: uart_str_tx
// PURPOSE
//  UART 8N1 string transmitter: on a start pulse, reads a byte string from a BRAM read port
//  beginning at BASE and serializes it LSB-first on tx. Pulses done when the string is finished.
//  It is the transmit end of the board's UART command link and sends the reply string held in
//  the TX-string region of the shared byte memory.
// PARAMETERS
//  WIDTH         8    data width of BRAM words and UART frames
//  LEN           256  total BRAM depth; address width AW = bits(LEN-1)+1 (9 for LEN=256)
//  BASE          128  first address of the TX-string region
//  CLKS_PER_BIT  104  clk cycles per UART bit (12 MHz / 115200)
//  NUL_TERM      1    1: a 0x00 byte ends the string early; the 0x00 byte is not sent
// PORTS
//  clk      in   1      clock
//  rst      in   1      reset, synchronous, active-high
//  start    in   1      single-cycle request; sampled only in IDLE
//  len      in   AW     bytes to send; sampled with start
//  addr     out  AW     BRAM read address, registered
//  rd_data  in   WIDTH  BRAM read data, valid 1 cycle after addr
//  tx       out  1      serial line, registered, idle high
//  busy     out  1      high from the cycle after start is accepted through the last stop bit
//  done     out  1      single-cycle pulse at the end of the string
// BEHAVIOUR
//  Reset: tx=1, busy=0, done=0, addr=BASE, state=IDLE; the counters and the index are cleared.
//   Reset mid-frame aborts the frame: tx=1 from the next cycle and no done pulse.
//  Length: n = min(len, LEN-BASE). The index i runs 0..n-1 and addr = BASE+i. addr never leaves
//   the range BASE..LEN-1.
//  States: IDLE -> FETCH -> LOAD -> START -> DATA -> STOP -> (FETCH | FIN) -> IDLE.
//   IDLE:  if start and n==0, go to FIN. If start and n>0, latch n, set addr=BASE and go to FETCH.
//   FETCH: 1 cycle; addr is stable and the BRAM read is in flight.
//   LOAD:  1 cycle; capture rd_data into the shift register. If NUL_TERM and rd_data==0, go to FIN.
//   START: tx=0 for CLKS_PER_BIT cycles.
//   DATA:  8 bits LSB first, each bit held for CLKS_PER_BIT cycles.
//   STOP:  tx=1 for CLKS_PER_BIT cycles. Then i++. If i==n go to FIN; else set addr=BASE+i and go to FETCH.
//   FIN:   done=1 for 1 cycle, busy=0; return to IDLE.
//  Timing: start is sampled at cycle 0, addr=BASE at cycle 1, tx falls at cycle 3.
//   One frame = 10*CLKS_PER_BIT cycles. Inter-byte gap = 2 idle-high cycles (FETCH and LOAD).
//  start while busy is ignored and has no side effect. start during FIN is also ignored.
//  tx=1 in every state except START and DATA. done and busy are never high in the same cycle.
//  The bit counter and the baud counter are sized by clog2 of their limits and do not wrap
//   mid-bit. The baud counter restarts at 0 on every state entry.
// TESTING (bench: CLKS_PER_BIT=4, BRAM model with 1-cycle read latency)
//  mem[128]=0x41, len=1, pulse start -> tx low from cycle 3 for 4 cycles, then 1,0,0,0,0,0,1,0
//   (4 cycles each), stop high 4 cycles; done at cycle 43, busy low at 43.
//  len=0 -> no tx activity, addr unchanged, done pulse at cycle 1, busy never high.
//  mem[128..130]="Hi\0", len=5, NUL_TERM=1 -> only 'H','i' sent; addr reaches 130; done follows the
//   LOAD of 0x00; no third frame.
//  start re-pulsed at cycles 5 and 20 during a 1-byte send -> exactly one frame, one done pulse.
//  rst asserted at cycle 15 mid-DATA -> tx=1 and busy=0 from cycle 16, no done; a new start then
//   sends a full correct frame.
//  len=200 with BASE=128, LEN=256 -> exactly 128 frames (addr 128..255); addr never exceeds 255;
//   each frame's byte matches mem.

Source files
------------

// File: rtl/uart_str_tx.sv
// ---------------------------------------------------------------------------
// uart_str_tx
//
// UART 8N1 string transmitter. A single-cycle start pulse in IDLE launches
// transmission of a byte string read from a BRAM port, beginning at address
// BASE. Each byte is sent as one frame: a low start bit, WIDTH data bits
// LSB first, and a high stop bit, every bit held for CLKS_PER_BIT cycles.
// The string ends after min(len, LEN-BASE) bytes, or earlier on a 0x00 byte
// when NUL_TERM is set (the 0x00 itself is not sent). A one-cycle done pulse
// marks the end of the string.
//
// Ports
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      request pulse, only honoured in IDLE
//   len      in   AW     number of bytes to send, sampled with start
//   addr     out  AW     registered BRAM read address (BASE..LEN-1)
//   rd_data  in   WIDTH  BRAM read data, valid one cycle after addr
//   tx       out  1      registered serial line, idles high
//   busy     out  1      high from the cycle after start is accepted
//                        through the last stop bit
//   done     out  1      single-cycle end-of-string pulse
// ---------------------------------------------------------------------------
module uart_str_tx #(
    parameter int WIDTH        = 8,
    parameter int LEN          = 256,
    parameter int BASE         = 128,
    parameter int CLKS_PER_BIT = 104,
    parameter int NUL_TERM     = 1,
    localparam int AW          = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    len,
    output logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    // Counter widths follow their limits so neither counter can wrap mid-bit.
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(WIDTH - 1);
    localparam logic [AW-1:0] BASE_A    = AW'(BASE);
    localparam logic [AW-1:0] REGION    = AW'(LEN - BASE);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    baud_q,  baud_d;
    logic [NW-1:0]    bit_q,   bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [AW-1:0]    idx_q,   idx_d;
    logic [AW-1:0]    n_q,     n_d;
    logic [AW-1:0]    addr_q,  addr_d;
    logic             tx_q,    tx_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             baud_end;
    logic             bit_end;
    logic [AW-1:0]    len_clip;

    assign baud_end = (baud_q == BAUD_LAST);
    assign bit_end  = (bit_q == BIT_LAST);

    // Clamp the request to the TX-string region so addr stays in BASE..LEN-1.
    assign len_clip = (len > REGION) ? REGION : len;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        n_d     = n_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_clip == '0) begin
                        state_d = S_FIN;
                    end else begin
                        n_d     = len_clip;
                        idx_d   = '0;
                        addr_d  = BASE_A;
                        state_d = S_FETCH;
                    end
                end
            end

            // addr is stable here; the BRAM read completes during this cycle.
            S_FETCH: state_d = S_LOAD;

            S_LOAD: begin
                shift_d = rd_data;
                if ((NUL_TERM != 0) && (rd_data == '0)) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_end) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + NW'(1);
                    end
                end
            end

            S_STOP: begin
                if (baud_end) begin
                    idx_d = idx_q + AW'(1);
                    if (idx_d == n_q) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = BASE_A + idx_d;
                        state_d = S_FETCH;
                    end
                end
            end

            // start is deliberately not looked at here.
            S_FIN: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // Baud counter: cleared on every state entry, and at each bit boundary
    // inside DATA where the state does not change between bits.
    always_comb begin
        baud_d = '0;
        if (state_d == state_q) begin
            if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) begin
                baud_d = baud_end ? '0 : baud_q + BW'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state
    // register rather than lagging it by one cycle.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        if ((state_d != S_IDLE) && (state_d != S_FIN)) begin
            busy_d = 1'b1;
        end
        if (state_d == S_FIN) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            addr_q  <= BASE_A;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr = addr_q;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_str_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_str_tx
//
// Directed-plus-random bench for uart_str_tx (CLKS_PER_BIT=4, NUL_TERM=1).
// A 1-cycle-latency BRAM model feeds the DUT. For each request the bench
// derives, from the byte string in memory, the list of frames, the cycle of
// the done pulse, and hence the expected tx/busy/done/addr for every cycle.
// Cycle k is observed at the falling edge after the k-th rising edge that
// follows the edge sampling start (cycle 0).
// ---------------------------------------------------------------------------
module tb_uart_str_tx;

    localparam int C  = 4;             // clocks per bit
    localparam int FR = 10 * C;        // cycles per frame
    localparam int P  = FR + 2;        // frame plus FETCH/LOAD gap

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] len_i;
    logic [8:0] addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] frames [$];
    int         n_m;
    int         d_m;
    int         nfetch_m;
    int         prev_addr;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[addr[7:0]];

    uart_str_tx #(
        .WIDTH       (8),
        .LEN         (256),
        .BASE        (128),
        .CLKS_PER_BIT(C),
        .NUL_TERM    (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len_i),
        .addr   (addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Derive frames and timing for a request of length len.
    task automatic build(input int len);
        logic [7:0] b;
        bit         nul_end;
        n_m = (len > 128) ? 128 : len;
        frames.delete();
        nul_end = 1'b0;
        for (int i = 0; i < n_m; i++) begin
            b = mem[128 + i];
            if (b == 8'h00) begin
                nul_end = 1'b1;
                break;
            end
            frames.push_back(b);
        end
        if (n_m == 0) begin
            d_m      = 1;
            nfetch_m = 0;
        end else if (nul_end) begin
            d_m      = 3 + frames.size() * P;
            nfetch_m = frames.size() + 1;
        end else begin
            d_m      = 1 + frames.size() * P;
            nfetch_m = frames.size();
        end
    endtask

    function automatic logic model_tx(input int k);
        int         off, f, p, b;
        logic [7:0] v;
        if (n_m == 0 || k < 3 || k >= d_m) return 1'b1;
        off = k - 3;
        f   = off / P;
        p   = off % P;
        if (f >= frames.size() || p >= FR) return 1'b1;
        b = p / C;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = frames[f];
        return v[b-1];
    endfunction

    function automatic int model_addr(input int k);
        int idx;
        if (nfetch_m == 0) return prev_addr;
        idx = (k - 1) / P;
        if (idx > nfetch_m - 1) idx = nfetch_m - 1;
        return 128 + idx;
    endfunction

    task automatic check_cycle(input int k);
        chk("tx",   k, 32'(tx),   32'(model_tx(k)));
        chk("busy", k, 32'(busy), 32'((n_m > 0) && (k >= 1) && (k < d_m)));
        chk("done", k, 32'(done), 32'(k == d_m));
        chk("addr", k, 32'(addr), 32'(model_addr(k)));
    endtask

    // Full request: start at cycle 0, optional extra start pulses at cycles e1/e2.
    task automatic run(input int len, input int e1, input int e2);
        build(len);
        @(negedge clk);
        start = 1'b1;
        len_i = 9'(len);
        for (int k = 1; k <= d_m + 4; k++) begin
            @(negedge clk);
            check_cycle(k);
            start = (k == e1) || (k == e2);
        end
        start     = 1'b0;
        prev_addr = model_addr(d_m);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len_i = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        repeat (3) @(negedge clk);
        chk("rst_tx",   0, 32'(tx),   32'd1);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_addr", 0, 32'(addr), 32'd128);
        rst       = 1'b0;
        prev_addr = 128;
        @(negedge clk);

        // single 'A'
        mem[128] = 8'h41;
        run(1, -1, -1);

        // zero length
        run(0, -1, -1);

        // NUL-terminated "Hi"
        mem[128] = 8'h48;
        mem[129] = 8'h69;
        mem[130] = 8'h00;
        run(5, -1, -1);

        // start re-pulsed while busy
        mem[128] = 8'($urandom_range(1, 255));
        run(1, 5, 20);

        // reset mid-DATA aborts the frame
        mem[128] = 8'($urandom_range(1, 255));
        build(1);
        @(negedge clk);
        start = 1'b1;
        len_i = 9'd1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check_cycle(k);
            start = 1'b0;
        end
        rst = 1'b1;
        for (int k = 16; k <= 24; k++) begin
            @(negedge clk);
            chk("abort_tx",   k, 32'(tx),   32'd1);
            chk("abort_busy", k, 32'(busy), 32'd0);
            chk("abort_done", k, 32'(done), 32'd0);
            chk("abort_addr", k, 32'(addr), 32'd128);
            rst = 1'b0;
        end
        prev_addr = 128;
        mem[128]  = 8'($urandom_range(1, 255));
        run(1, -1, -1);

        // random short strings with occasional NUL bytes
        for (int r = 0; r < 4; r++) begin
            for (int i = 128; i < 136; i++)
                mem[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run(int'($urandom_range(0, 6)), -1, -1);
        end

        // over-long request clamps to the region
        for (int i = 128; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        run(200, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
